bus_cycle_unit: RTL and testbench
=================================

// Module: bus_cycle_unit
// PURPOSE
//  Parametrised external bus cycle engine for the 6502-family cores. It replaces the fixed
//  16-bit address/8-bit data pad latches and the write latch with one sequenced unit.
//  - Core side: request/response handshake.
//  - Pad side: A, D, RnW and SYNC, with RDY stalls on reads (and optionally on writes).
//  - Idle and reset data value is all ones, matching bus precharge.
// PARAMETERS
//  AW            16  address bus width
//  DW             8  data bus width
//  WAIT_W         3  width of the programmable wait-state counter (used only with BUS_WAITGEN_EN)
//  RDY_ON_WRITE   0  1: RDY=0 also stalls write cycles (CMOS style); 0: writes ignore RDY (NMOS style)
// PORTS
//  PHI0       in   1       clock; all state changes on the rising edge
//  RESP       in   1       synchronous reset, active-high
//  req_valid  in   1       core requests a bus cycle
//  req_ready  out  1       unit accepts a request on this edge
//  req_we     in   1       1 = write cycle, 0 = read cycle
//  req_addr   in   AW      cycle address
//  req_wdata  in   DW      write data
//  req_sync   in   1       cycle is an opcode fetch (T1)
//  rsp_valid  out  1       one-clock pulse: cycle complete; rsp_rdata is valid for reads
//  rsp_rdata  out  DW      last captured read data; held between reads
//  A          out  AW      external address bus
//  D_out      out  DW      external data out
//  D_oe       out  1       data output enable
//  D_in       in   DW      external data in
//  RnW        out  1       1 = read, 0 = write
//  SYNC       out  1       opcode fetch marker
//  RDY        in   1       1 = memory ready
//  wait_cfg   in   WAIT_W  wait states per cycle (port exists only with BUS_WAITGEN_EN)
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (RESP=1 at an edge):
//   - State = IDLE; A=0, D_out=0, D_oe=0, RnW=1, SYNC=0.
//   - rsp_valid=0, rsp_rdata={DW{1'b1}}, busy=0.
//   - Reset overrides every other input, including a request on the same edge.
//  States IDLE, ADDR, WAIT, DATA; all outputs are registered except req_ready and busy.
//  IDLE:
//   - req_ready=1. On req_valid, latch we/addr/wdata/sync, then go to ADDR.
//   - A holds the last address; RnW=1; SYNC=0; D_oe=0.
//  ADDR:
//   - A=addr, RnW=~we, SYNC=sync, D_oe=0.
//   - Next state is DATA, or WAIT when the wait count is nonzero.
//  DATA, read:
//   - RDY=0: stay in DATA; A, RnW and SYNC are held stable.
//   - RDY=1: capture D_in into rsp_rdata; rsp_valid=1 in the following clock.
//  DATA, write:
//   - D_oe=1, D_out=wdata.
//   - The cycle completes this clock unless RDY_ON_WRITE=1 and RDY=0, in which case the unit stays.
//   - D_oe drops on the completing edge; a write never asserts rsp_valid-with-data, but it still pulses rsp_valid.
//  Completion:
//   - req_ready=1 combinationally in the completing DATA clock.
//   - If req_valid=1 there, go directly to ADDR with the new request (back-to-back, 2-clock minimum cycle).
//   - Otherwise go to IDLE.
//  Latency: request accepted at edge N -> ADDR after N -> DATA after N+1 -> rsp_valid high after N+2
//   (with zero stalls and zero waits).
//  Stall and wait clocks add 1:1 to this latency.
//  Reset mid-cycle:
//   - The cycle is aborted; no rsp_valid; rsp_rdata returns to all ones.
//   - D_oe=0 after the reset edge.
//  Write followed by read: D_oe is already 0 in the read's ADDR clock, so no bus contention.
//  Widths: A, D and rsp_rdata are passed through unmodified, with no truncation or sign extension.
// CONFIGURATION
//  BUS_WAITGEN_EN defined:
//   - wait_cfg port exists; it is sampled when the request is accepted.
//   - On leaving ADDR, a counter is loaded with wait_cfg; the unit stays in WAIT for wait_cfg clocks
//     (outputs as in ADDR), then goes to DATA.
//   - wait_cfg=0 skips WAIT.
//   - RDY is evaluated only in DATA.
//  BUS_WAITGEN_EN undefined:
//   - No wait_cfg port and no WAIT state; ADDR always goes to DATA.
//   - RDY is the only source of stalls.
// TESTING
//  Reset: RESP=1 for 2 clocks -> A=0000, RnW=1, D_oe=0, SYNC=0, rsp_rdata=FF, req_ready=1, busy=0.
//  Read FFFC with sync=1, RDY=1, D_in=34 -> A=FFFC and SYNC=1 from N+1.
//   Then rsp_valid pulses after N+2, rsp_rdata=34.
//  Read 0010 with RDY=0 for 3 clocks in DATA -> A stays 0010, rsp_valid arrives 3 clocks later,
//   exactly one pulse, data=D_in sampled when RDY=1.
//  Write 0200=A5 with RDY=0 and RDY_ON_WRITE=0 -> completes unstalled, RnW=0, D_oe=1 for 1 clock, D_out=A5.
//   Same write with RDY_ON_WRITE=1 -> D_oe is held until RDY=1.
//  Back-to-back reads 1000 then 1001 with req_valid held -> A changes every 2 clocks, two rsp_valid pulses.
//   Then RESP=1 during a RDY=0 stall -> IDLE, no rsp_valid, rsp_rdata=FF.
//  With BUS_WAITGEN_EN and wait_cfg=2, read 3000 -> ADDR, WAIT, WAIT, DATA;
//   rsp_valid after N+4; wait_cfg=0 gives N+2.

Source files
------------

// File: rtl/bus_cycle_unit.sv
// External bus cycle engine for 6502-family cores: core request/response in, A/D/RnW/SYNC pads out.
// Optional feature macro: BUS_WAITGEN_EN (adds the wait_cfg port and a programmable WAIT state).
module bus_cycle_unit #(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 8,
  parameter int unsigned WAIT_W       = 3,
  parameter bit          RDY_ON_WRITE = 1'b0
) (
  input  logic              PHI0,
  input  logic              RESP,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic              req_sync,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [AW-1:0]     A,
  output logic [DW-1:0]     D_out,
  output logic              D_oe,
  input  logic [DW-1:0]     D_in,
  output logic              RnW,
  output logic              SYNC,
  input  logic              RDY,
`ifdef BUS_WAITGEN_EN
  input  logic [WAIT_W-1:0] wait_cfg,
`endif
  output logic              busy
);

  typedef logic [WAIT_W-1:0] wait_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
`ifdef BUS_WAITGEN_EN
    , S_WAIT = 2'd3
`endif
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_a;
  logic [DW-1:0]   r_dout;
  logic            r_doe;
  logic            r_rnw;
  logic            r_sync;
  logic            r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic            r_we;
  logic [DW-1:0]   r_wdata;

  state_t          w_state_nxt;
  logic [AW-1:0]   w_a_nxt;
  logic [DW-1:0]   w_dout_nxt;
  logic            w_doe_nxt;
  logic            w_rnw_nxt;
  logic            w_sync_nxt;
  logic            w_rvalid_nxt;
  logic [DW-1:0]   w_rdata_nxt;
  logic            w_we_nxt;
  logic [DW-1:0]   w_wdata_nxt;
  logic            w_ready;
  logic            w_accept;
  logic            w_complete;
  logic            w_enter_data;

`ifdef BUS_WAITGEN_EN
  wait_t           r_wait_cfg;
  wait_t           r_wait_cnt;
  wait_t           w_wait_cfg_nxt;
  wait_t           w_wait_cnt_nxt;
`endif

  always_ff @(posedge PHI0) begin
    if (RESP) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_dout      <= '0;
      r_doe       <= 1'b0;
      r_rnw       <= 1'b1;
      r_sync      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '1;
      r_we        <= 1'b0;
      r_wdata     <= '0;
`ifdef BUS_WAITGEN_EN
      r_wait_cfg  <= '0;
      r_wait_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_dout      <= w_dout_nxt;
      r_doe       <= w_doe_nxt;
      r_rnw       <= w_rnw_nxt;
      r_sync      <= w_sync_nxt;
      r_rsp_valid <= w_rvalid_nxt;
      r_rsp_rdata <= w_rdata_nxt;
      r_we        <= w_we_nxt;
      r_wdata     <= w_wdata_nxt;
`ifdef BUS_WAITGEN_EN
      r_wait_cfg  <= w_wait_cfg_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_dout_nxt     = r_dout;
    w_doe_nxt      = r_doe;
    w_rnw_nxt      = r_rnw;
    w_sync_nxt     = r_sync;
    w_rvalid_nxt   = 1'b0;
    w_rdata_nxt    = r_rsp_rdata;
    w_we_nxt       = r_we;
    w_wdata_nxt    = r_wdata;
    w_ready        = 1'b0;
    w_accept       = 1'b0;
    w_complete     = 1'b0;
    w_enter_data   = 1'b0;
`ifdef BUS_WAITGEN_EN
    w_wait_cfg_nxt = r_wait_cfg;
    w_wait_cnt_nxt = r_wait_cnt;
`endif

    case (r_state)
      S_IDLE: begin
        w_ready    = 1'b1;
        w_rnw_nxt  = 1'b1;
        w_sync_nxt = 1'b0;
        w_doe_nxt  = 1'b0;
      end
      S_ADDR: begin
`ifdef BUS_WAITGEN_EN
        if (r_wait_cfg != '0) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = r_wait_cfg;
        end else begin
          w_enter_data = 1'b1;
        end
`else
        w_enter_data = 1'b1;
`endif
      end
`ifdef BUS_WAITGEN_EN
      S_WAIT: begin
        if (r_wait_cnt == wait_t'(1)) begin
          w_enter_data = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - wait_t'(1);
        end
      end
`endif
      S_DATA: begin
        if (r_we) begin
          w_complete = !(RDY_ON_WRITE && !RDY);
        end else begin
          w_complete = RDY;
          if (RDY) begin
            w_rdata_nxt = D_in;
          end
        end
        if (w_complete) begin
          w_ready      = 1'b1;
          w_rvalid_nxt = 1'b1;
          w_doe_nxt    = 1'b0;
          w_rnw_nxt    = 1'b1;
          w_sync_nxt   = 1'b0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Data drive starts on the edge into DATA so a preceding write's D_oe is never
    // still high in the following cycle's ADDR clock.
    if (w_enter_data) begin
      w_state_nxt = S_DATA;
      w_doe_nxt   = r_we;
      if (r_we) begin
        w_dout_nxt = r_wdata;
      end
    end

    // Acceptance wins over the completion defaults so back-to-back cycles skip IDLE.
    w_accept = w_ready && req_valid;
    if (w_accept) begin
      w_state_nxt    = S_ADDR;
      w_a_nxt        = req_addr;
      w_rnw_nxt      = ~req_we;
      w_sync_nxt     = req_sync;
      w_doe_nxt      = 1'b0;
      w_we_nxt       = req_we;
      w_wdata_nxt    = req_wdata;
`ifdef BUS_WAITGEN_EN
      w_wait_cfg_nxt = wait_cfg;
`endif
    end
  end

  assign req_ready = w_ready;
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign A         = r_a;
  assign D_out     = r_dout;
  assign D_oe      = r_doe;
  assign RnW       = r_rnw;
  assign SYNC      = r_sync;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Scoreboard bench for bus_cycle_unit: NMOS-style (dut0) and CMOS-style write stall (dut1) instances.
module tb_bus_cycle_unit;

  logic        PHI0 = 1'b0;
  logic        RESP;
  logic        req_valid0, req_valid1;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_sync;
  logic [7:0]  D_in;
  logic        RDY;
`ifdef BUS_WAITGEN_EN
  logic [2:0]  wait_cfg;
`endif

  logic        ready0, rsp_valid0, doe0, rnw0, sync0, busy0;
  logic [7:0]  rdata0, dout0;
  logic [15:0] a0;
  logic        ready1, rsp_valid1, doe1, rnw1, sync1, busy1;
  logic [7:0]  rdata1, dout1;
  logic [15:0] a1;

  typedef struct {
    logic [7:0] rdata;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 PHI0 = ~PHI0;
  always @(posedge PHI0) cyc <= cyc + 1;

  bus_cycle_unit #(.AW(16), .DW(8), .WAIT_W(3), .RDY_ON_WRITE(1'b0)) dut0 (
    .PHI0(PHI0), .RESP(RESP), .req_valid(req_valid0), .req_ready(ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sync(req_sync), .rsp_valid(rsp_valid0),
    .rsp_rdata(rdata0), .A(a0), .D_out(dout0), .D_oe(doe0), .D_in(D_in), .RnW(rnw0),
    .SYNC(sync0), .RDY(RDY),
`ifdef BUS_WAITGEN_EN
    .wait_cfg(wait_cfg),
`endif
    .busy(busy0)
  );

  bus_cycle_unit #(.AW(16), .DW(8), .WAIT_W(3), .RDY_ON_WRITE(1'b1)) dut1 (
    .PHI0(PHI0), .RESP(RESP), .req_valid(req_valid1), .req_ready(ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sync(req_sync), .rsp_valid(rsp_valid1),
    .rsp_rdata(rdata1), .A(a1), .D_out(dout1), .D_oe(doe1), .D_in(D_in), .RnW(rnw1),
    .SYNC(sync1), .RDY(RDY),
`ifdef BUS_WAITGEN_EN
    .wait_cfg(wait_cfg),
`endif
    .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge PHI0);
      if (rsp_valid0 === 1'b1) begin
        if (q0.size() == 0) begin
          check("dut0_unexpected_rsp", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = q0.pop_front();
          check("dut0_rsp_rdata", 32'(rdata0), 32'(e.rdata));
          check("dut0_rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (rsp_valid1 === 1'b1) begin
        if (q1.size() == 0) begin
          check("dut1_unexpected_rsp", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          e = q1.pop_front();
          check("dut1_rsp_rdata", 32'(rdata1), 32'(e.rdata));
          check("dut1_rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PHI0);
    #1;
  endtask

  // Presents one request to the chosen DUT for one edge; expected pulse cycle is accept + 2 + extra.
  task automatic issue(input int which, input logic we, input logic [15:0] addr,
                       input logic [7:0] wdata, input logic sync, input bit expect_rsp,
                       input logic [7:0] rexp, input int extra);
    exp_t e;
    check(which == 0 ? "dut0_ready_before_req" : "dut1_ready_before_req",
          32'(which == 0 ? ready0 : ready1), 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_sync = sync;
    if (which == 0) req_valid0 = 1'b1; else req_valid1 = 1'b1;
    tick(1);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    if (expect_rsp) begin
      e.rdata = rexp;
      e.cyc   = cyc + 2 + extra;
      if (which == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    RESP = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_sync = 1'b0; D_in = '0; RDY = 1'b1;
`ifdef BUS_WAITGEN_EN
    wait_cfg = '0;
`endif
    fork
      monitor();
    join_none

    // Reset
    tick(2);
    RESP = 1'b0;
    @(negedge PHI0);
    check("rst_A", 32'(a0), 32'h0000);
    check("rst_RnW", 32'(rnw0), 32'd1);
    check("rst_D_oe", 32'(doe0), 32'd0);
    check("rst_SYNC", 32'(sync0), 32'd0);
    check("rst_rdata", 32'(rdata0), 32'hFF);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    check("rst_dut1_D_oe", 32'(doe1), 32'd0);
    tick(1);

    // Opcode fetch read FFFC
    D_in = 8'h34; RDY = 1'b1;
    issue(0, 1'b0, 16'hFFFC, 8'h00, 1'b1, 1'b1, 8'h34, 0);
    @(negedge PHI0);
    check("fetch_addr_A", 32'(a0), 32'hFFFC);
    check("fetch_addr_SYNC", 32'(sync0), 32'd1);
    check("fetch_addr_RnW", 32'(rnw0), 32'd1);
    check("fetch_addr_D_oe", 32'(doe0), 32'd0);
    check("fetch_addr_busy", 32'(busy0), 32'd1);
    check("fetch_addr_ready", 32'(ready0), 32'd0);
    tick(1);
    @(negedge PHI0);
    check("fetch_data_A", 32'(a0), 32'hFFFC);
    check("fetch_data_SYNC", 32'(sync0), 32'd1);
    check("fetch_data_ready", 32'(ready0), 32'd1);
    tick(1);
    @(negedge PHI0);
    check("fetch_done_SYNC", 32'(sync0), 32'd0);
    check("fetch_done_busy", 32'(busy0), 32'd0);
    tick(1);

    // Read 0010 with three RDY=0 stall clocks
    RDY = 1'b0; D_in = 8'h00;
    issue(0, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b1, 8'h5A, 3);
    tick(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge PHI0);
      check("stall_A", 32'(a0), 32'h0010);
      check("stall_ready", 32'(ready0), 32'd0);
      check("stall_RnW", 32'(rnw0), 32'd1);
      tick(1);
    end
    RDY = 1'b1; D_in = 8'h5A;
    tick(1);
    @(negedge PHI0);
    check("stall_done_A_held", 32'(a0), 32'h0010);
    tick(1);

    // Write 0200=A5 with RDY=0, NMOS style: no stall
    RDY = 1'b0;
    issue(0, 1'b1, 16'h0200, 8'hA5, 1'b0, 1'b1, 8'h5A, 0);
    @(negedge PHI0);
    check("wr_addr_RnW", 32'(rnw0), 32'd0);
    check("wr_addr_D_oe", 32'(doe0), 32'd0);
    tick(1);
    @(negedge PHI0);
    check("wr_data_D_oe", 32'(doe0), 32'd1);
    check("wr_data_D_out", 32'(dout0), 32'hA5);
    check("wr_data_RnW", 32'(rnw0), 32'd0);
    check("wr_data_ready", 32'(ready0), 32'd1);
    tick(1);
    @(negedge PHI0);
    check("wr_done_D_oe", 32'(doe0), 32'd0);
    check("wr_done_RnW", 32'(rnw0), 32'd1);
    check("wr_done_busy", 32'(busy0), 32'd0);
    tick(1);

    // Same write, CMOS style: held two clocks by RDY=0
    RDY = 1'b0;
    issue(1, 1'b1, 16'h0200, 8'hA5, 1'b0, 1'b1, 8'hFF, 2);
    tick(1);
    @(negedge PHI0);
    check("cwr_D_oe_1", 32'(doe1), 32'd1);
    check("cwr_D_out", 32'(dout1), 32'hA5);
    check("cwr_ready_stall", 32'(ready1), 32'd0);
    tick(1);
    @(negedge PHI0);
    check("cwr_D_oe_2", 32'(doe1), 32'd1);
    check("cwr_busy", 32'(busy1), 32'd1);
    tick(1);
    RDY = 1'b1;
    @(negedge PHI0);
    check("cwr_ready_go", 32'(ready1), 32'd1);
    check("cwr_D_oe_3", 32'(doe1), 32'd1);
    tick(1);
    @(negedge PHI0);
    check("cwr_done_D_oe", 32'(doe1), 32'd0);
    tick(1);

    // Back-to-back reads 1000, 1001 with req_valid held
    RDY = 1'b1; D_in = 8'h11;
    req_we = 1'b0; req_addr = 16'h1000; req_sync = 1'b0; req_valid0 = 1'b1;
    tick(1);
    e.rdata = 8'h11; e.cyc = cyc + 2; q0.push_back(e);
    req_addr = 16'h1001;
    @(negedge PHI0);
    check("b2b_A_first", 32'(a0), 32'h1000);
    tick(1);
    @(negedge PHI0);
    check("b2b_ready_data", 32'(ready0), 32'd1);
    check("b2b_A_first_held", 32'(a0), 32'h1000);
    tick(1);
    e.rdata = 8'h22; e.cyc = cyc + 2; q0.push_back(e);
    req_valid0 = 1'b0; D_in = 8'h22;
    @(negedge PHI0);
    check("b2b_A_second", 32'(a0), 32'h1001);
    check("b2b_busy", 32'(busy0), 32'd1);
    tick(3);

    // Reset during a read stall: aborted, no pulse
    RDY = 1'b0;
    issue(0, 1'b0, 16'h0040, 8'h00, 1'b0, 1'b0, 8'h00, 0);
    tick(2);
    RESP = 1'b1;
    tick(1);
    RESP = 1'b0;
    @(negedge PHI0);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_rdata", 32'(rdata0), 32'hFF);
    check("abort_A", 32'(a0), 32'h0000);
    check("abort_ready", 32'(ready0), 32'd1);
    tick(1);

    // Reset during a stalled CMOS write drops D_oe
    RDY = 1'b0;
    issue(1, 1'b1, 16'h0300, 8'h3C, 1'b0, 1'b0, 8'h00, 0);
    tick(1);
    @(negedge PHI0);
    check("wabort_D_oe_before", 32'(doe1), 32'd1);
    RESP = 1'b1;
    tick(1);
    RESP = 1'b0;
    @(negedge PHI0);
    check("wabort_D_oe_after", 32'(doe1), 32'd0);
    check("wabort_busy", 32'(busy1), 32'd0);
    check("wabort_RnW", 32'(rnw1), 32'd1);
    tick(1);

`ifdef BUS_WAITGEN_EN
    // Two wait states, then zero wait states
    RDY = 1'b1; D_in = 8'h77; wait_cfg = 3'd2;
    issue(0, 1'b0, 16'h3000, 8'h00, 1'b0, 1'b1, 8'h77, 2);
    tick(1);
    @(negedge PHI0);
    check("wait_A", 32'(a0), 32'h3000);
    check("wait_D_oe", 32'(doe0), 32'd0);
    check("wait_ready", 32'(ready0), 32'd0);
    tick(4);
    D_in = 8'h78; wait_cfg = 3'd0;
    issue(0, 1'b0, 16'h3001, 8'h00, 1'b0, 1'b1, 8'h78, 0);
    tick(3);
`endif

    tick(3);
    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut1_queue_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
